// File: rtl/md_sched.sv
// md_sched: EX-stage multiply/divide scheduler with a fixed busy window.
// Ports: clk, reset (async, active-low), start/op/rs/rt issue, busy, done, hi, lo.
// Optional MADD/MSUB (ops 6/7) accumulate support: define MDU_MADD_EN.
module md_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pend_hi, pend_lo;
  logic [31:0] pend_hi_nxt, pend_lo_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        done_nxt;

  logic signed [63:0] a_s, b_s;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sa, sb, q_s, r_s;
  logic [31:0]        q_u, r_u;
  logic               div_ovf;

  always_comb begin
    a_s    = {{32{rs[31]}}, rs};
    b_s    = {{32{rt[31]}}, rt};
    prod_s = a_s * b_s;
    prod_u = {32'b0, rs} * {32'b0, rt};
    sa     = rs;
    sb     = rt;
    // most-negative / -1 overflows a signed divide; pin the result
    div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (rt != 32'd0) begin
      q_u = rs / rt;
      r_u = rs % rt;
      if (!div_ovf) begin
        q_s = sa / sb;
        r_s = sa % sb;
      end else begin
        q_s = 32'sh8000_0000;
        r_s = '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    hi_nxt      = hi;
    lo_nxt      = lo;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              state_nxt = RUN;
              cnt_nxt   = MUL_LD;
              {pend_hi_nxt, pend_lo_nxt} = prod_s;
            end
            3'd1: begin
              state_nxt = RUN;
              cnt_nxt   = MUL_LD;
              {pend_hi_nxt, pend_lo_nxt} = prod_u;
            end
            3'd2: begin
              state_nxt = RUN;
              cnt_nxt   = DIV_LD;
              // divide by zero keeps the old HI/LO
              if (rt != 32'd0) begin
                pend_hi_nxt = r_s;
                pend_lo_nxt = q_s;
              end else begin
                pend_hi_nxt = hi;
                pend_lo_nxt = lo;
              end
            end
            3'd3: begin
              state_nxt = RUN;
              cnt_nxt   = DIV_LD;
              if (rt != 32'd0) begin
                pend_hi_nxt = r_u;
                pend_lo_nxt = q_u;
              end else begin
                pend_hi_nxt = hi;
                pend_lo_nxt = lo;
              end
            end
            3'd4: hi_nxt = rs;
            3'd5: lo_nxt = rs;
`ifdef MDU_MADD_EN
            3'd6: begin
              state_nxt = RUN;
              cnt_nxt   = MUL_LD;
              {pend_hi_nxt, pend_lo_nxt} = {hi, lo} + prod_s;
            end
            3'd7: begin
              state_nxt = RUN;
              cnt_nxt   = MUL_LD;
              {pend_hi_nxt, pend_lo_nxt} = {hi, lo} - prod_s;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      done    <= done_nxt;
    end
  end

  // state is a flop, so busy is a registered signal
  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched.
// Checks reset, MULT/DIV/DIVU/MTHI/MTLO, back-to-back and abort.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  md_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue op, walk the busy window, leave bench in the done cycle
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh,
                        input logic [31:0] el, input bit inject);
    start = 1'b1; op = o; rs = a; rt = b;
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd0);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy_win"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      if (inject && i == 1) begin
        start = 1'b1; op = 3'd4; rs = 32'hDEAD_BEEF;
      end
      step();
      start = 1'b0;
    end
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    step();

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    step();
    chk("mult_done_pulse", 32'(done), 32'd0);

    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu0", 3'd3, 32'd7, 32'd0, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 10,
           32'd2, 32'd14, 1'b0);
    step();

    start = 1'b1; op = 3'd4; rs = 32'h1234_5678;
    step();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'd0);
    op = 3'd5; rs = 32'h9ABC_DEF0;
    step();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_done", 32'(done), 32'd0);

    run_op("b2b1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    run_op("b2b2", 3'd1, 32'd2, 32'd3, 5,
           32'd0, 32'd6, 1'b1);
    step();

`ifdef MDU_MADD_EN
    start = 1'b1; op = 3'd4; rs = 32'd0;
    step();
    op = 3'd5; rs = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    run_op("madd", 3'd6, 32'd1, 32'd1, 5,
           32'd1, 32'd0, 1'b0);
    run_op("msub", 3'd7, 32'd1, 32'd1, 5,
           32'd0, 32'hFFFF_FFFF, 1'b0);
    step();
`else
    start = 1'b1; op = 3'd6; rs = 32'd5; rt = 32'd5;
    step();
    start = 1'b0;
    chk("undef_busy", 32'(busy), 32'd0);
    chk("undef_hi", hi, 32'd0);
    chk("undef_lo", lo, 32'd6);
    step();
    chk("undef_done", 32'(done), 32'd0);
`endif

    start = 1'b1; op = 3'd2; rs = 32'd50; rt = 32'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      step();
    end
    chk("abort_hi_after", hi, 32'd0);
    chk("abort_lo_after", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the EX stage of the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from EX and computes operands into pending result registers. It sequences a fixed-latency busy window, then commits HI/LO. Its `busy` output feeds the hazard unit's MD stall logic, and `hi`/`lo` feed MFHI/MFLO.

## Interface
- MUL_CYCLES, 5, busy-window length for MULT/MULTU (legal 1..15)
- DIV_CYCLES, 10, busy-window length for DIV/DIVU (legal 1..15)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  issue strobe from EX, valid for one cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB (6/7 only with MDU_MADD_EN)
- rs  input  32  operand A / move source
- rt  input  32  operand B
- busy  output  1  multi-cycle operation in flight
- done  output  1  one-cycle pulse on the cycle HI/LO commit from a multi-cycle operation
- hi  output  32  architectural HI
- lo  output  32  architectural LO

## Operation
- States: IDLE, RUN.
- In IDLE, `start` with a multi-cycle op goes to RUN.
  - The result is captured into pend_hi/pend_lo at that edge.
  - cnt is loaded with MUL_CYCLES-1 or DIV_CYCLES-1.
- In RUN, cnt decrements each cycle. At cnt==0, the next edge commits pend_* to hi/lo, pulses `done` and returns to IDLE.
- MTHI/MTLO with `start` in IDLE write rs to hi or lo at the next edge. No busy, no done.
- `start` while busy=1 is ignored; the hazard unit guarantees it never occurs.
- The bench checks that it is ignored and that state is unchanged.
- MULT: signed 32x32, 64-bit product; hi = [63:32], lo = [31:0]. MULTU is the unsigned form.
- DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
  - DIVU is the unsigned form.
- Divide by zero: full DIV_CYCLES busy window, `done` pulses, hi/lo unchanged.
- Undefined op codes (6/7 without the macro) are treated as no-ops and do not enter RUN.

## Timing
- Reset (reset=0, asynchronous) forces IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, pend_*=0.
  - Reset mid-RUN aborts the operation; no commit.
- `busy` is registered. It is 0 in the `start` cycle and 1 from the next cycle for exactly MUL_CYCLES or DIV_CYCLES cycles.
- The hazard unit must OR `start` with `busy` for MFHI/MFLO stalls.
- Commit timing: hi/lo update on the same edge at which busy falls. `done` is high in the first cycle after that edge, i.e. the cycle in which the new hi/lo are visible.
- Back-to-back: a new `start` is accepted in the cycle after busy falls, which is the cycle `done` is high.
- MTHI/MTLO latency: 1 edge; the value is visible the next cycle.
- Exactly one HI/LO writer occurs per edge; there is no simultaneous-write case.

## Configuration
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 (MADD) uses the MUL_CYCLES window and commits {hi,lo} + signed(rs*rt).
  - op 7 (MSUB) uses the MUL_CYCLES window and commits {hi,lo} - signed(rs*rt).
  - The {hi,lo} used is the value sampled at issue, with 64-bit wrap-around.
- Undefined: ops 6/7 are no-ops, and the accumulate adder is not synthesized.

## Test plan
- Reset: drive reset=0 mid-DIV (cycle 4) -> busy=0, hi=lo=0 immediately; no done pulse afterwards.
- MULT with rs=0xFFFFFFFE, rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses 1 cycle.
- DIV with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with rs=7, rt=0 -> busy 10 cycles, done pulses, hi/lo unchanged.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles -> hi/lo visible 1 cycle after each, busy stays 0.
- Back-to-back MULTU 0xFFFFFFFF*0xFFFFFFFF then MULTU 2*3 issued in the done cycle:
  - First commit: hi=0xFFFFFFFE, lo=0x00000001.
  - Second commit, 5 cycles later: hi=0, lo=6.
  - A start injected while busy is ignored.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD rs=1, rt=1 -> hi=1, lo=0.
  - Then MSUB rs=1, rt=1 -> hi=0, lo=0xFFFFFFFF.
